// File: rtl/inter_arb_if.sv
// Request/transfer bundle for the inter_arb multi-master to multi-slave arbiter.
// The master modport is the environment side (requesting masters plus slave
// ready lines); the slave modport is the arbiter's own view of the same wires.
//
// Handshake rules:
//   in_valid[i] is a one-cycle strobe. It is accepted when busy_master[i]=0, or
//   in the cycle the master's pending request completes. Otherwise it is ignored.
//   valid_slave[s] and the payload stay stable until ready_slave[s] is sampled
//   high while valid is high. The following cycle carries a one-cycle
//   handshake_slave[s] pulse.
interface inter_arb_if #(
    parameter int N_MST  = 4,
    parameter int N_SLV  = 4,
    parameter int ADDR_W = 3,
    parameter int VAL_W  = 3
);
    localparam int SEL_W = $clog2(N_SLV);
    localparam int DW    = SEL_W + ADDR_W + VAL_W;

    logic [N_MST-1:0]    in_valid;
    logic [N_MST*DW-1:0] data_in;
    logic [N_SLV-1:0]    ready_slave;
    logic [N_SLV-1:0]    valid_slave;
    logic [ADDR_W-1:0]   addr_out;
    logic [VAL_W-1:0]    value_out;
    logic [N_SLV-1:0]    handshake_slave;
    logic [N_MST-1:0]    busy_master;

    modport master (
        output in_valid, data_in, ready_slave,
        input  valid_slave, addr_out, value_out, handshake_slave, busy_master
    );

    modport slave (
        input  in_valid, data_in, ready_slave,
        output valid_slave, addr_out, value_out, handshake_slave, busy_master
    );
endinterface

// File: rtl/inter_arb.sv
// inter_arb: each master has a one-entry request buffer. A three-state FSM
// (IDLE/SEND/HS) forwards one buffered request at a time to the slave that the
// request selects.
// Optional macro INTER_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
// Without it, fixed priority is used and the highest pending index wins.
module inter_arb #(
    parameter int N_MST  = 4,
    parameter int N_SLV  = 4,
    parameter int ADDR_W = 3,
    parameter int VAL_W  = 3
) (
    input  logic        clk,
    input  logic        rst,
    inter_arb_if.slave  bus,
    output logic [1:0]  state_dbg
);
    localparam int SEL_W = $clog2(N_SLV);
    localparam int DW    = SEL_W + ADDR_W + VAL_W;
    localparam int MW    = (N_MST > 1) ? $clog2(N_MST) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HS   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [N_MST-1:0] pend;
    logic [DW-1:0]    buf_q [N_MST];
    logic [MW-1:0]    grant_idx;
    logic [MW-1:0]    grant_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] new_sel;
    logic             any_pend;
    logic             load;
    logic             complete;
`ifdef INTER_ARB_ROUND_ROBIN_EN
    logic [MW-1:0]    rr_ptr;
`endif

    assign any_pend        = |pend;
    assign new_sel         = buf_q[grant_idx][DW-1 -: SEL_W];
    assign bus.busy_master = pend;
    assign state_dbg       = state;

    // Choose the winning master from the registered pending set only.
    always_comb begin
`ifdef INTER_ARB_ROUND_ROBIN_EN
        logic [MW-1:0] idx;
        grant_idx = '0;
        idx       = '0;
        // Walk backwards so the candidate nearest rr_ptr+1 is written last.
        for (int k = N_MST; k >= 1; k--) begin
            idx = MW'((int'(rr_ptr) + k) % N_MST);
            if (pend[idx]) grant_idx = idx;
        end
`else
        grant_idx = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (pend[i]) grant_idx = MW'(i);
        end
`endif
    end

    // Next-state and control strobes of the transfer FSM.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE: begin
                if (any_pend) begin
                    load     = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (bus.ready_slave[sel_q] && bus.valid_slave[sel_q]) begin
                    complete = 1'b1;
                    state_nx = HS;
                end
            end
            HS: begin
                if (any_pend) begin
                    load     = 1'b1;
                    state_nx = SEND;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Registered slave-side outputs and the current grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valid_slave     <= '0;
            bus.handshake_slave <= '0;
            bus.addr_out        <= '0;
            bus.value_out       <= '0;
            sel_q               <= '0;
            grant_q             <= '0;
        end else begin
            bus.handshake_slave <= '0;
            if (complete) begin
                bus.valid_slave     <= '0;
                bus.handshake_slave <= N_SLV'(1) << sel_q;
                bus.addr_out        <= '0;
                bus.value_out       <= '0;
            end else if (load) begin
                bus.valid_slave <= N_SLV'(1) << new_sel;
                bus.addr_out    <= buf_q[grant_idx][VAL_W +: ADDR_W];
                bus.value_out   <= buf_q[grant_idx][0 +: VAL_W];
                sel_q           <= new_sel;
                grant_q         <= grant_idx;
            end
        end
    end

    // Per-master request buffers. A new strobe in the completing cycle refills the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
            for (int i = 0; i < N_MST; i++) buf_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_MST; i++) begin
                if (bus.in_valid[i] && (!pend[i] || (complete && grant_q == MW'(i)))) begin
                    pend[i]  <= 1'b1;
                    buf_q[i] <= bus.data_in[i*DW +: DW];
                end else if (complete && grant_q == MW'(i)) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

`ifdef INTER_ARB_ROUND_ROBIN_EN
    // Round-robin pointer remembers the most recent grant.
    always_ff @(posedge clk) begin
        if (rst)       rr_ptr <= MW'(N_MST - 1);
        else if (load) rr_ptr <= grant_idx;
    end
`endif
endmodule

// File: tb/tb_inter_arb.sv
// Self-checking bench for inter_arb with the default configuration.
// Define INTER_ARB_ROUND_ROBIN_EN for both the RTL and this bench to check
// round-robin mode. Otherwise fixed priority is expected.
module tb_inter_arb;
    localparam int N_MST  = 4;
    localparam int N_SLV  = 4;
    localparam int ADDR_W = 3;
    localparam int VAL_W  = 3;
    localparam int SEL_W  = $clog2(N_SLV);
    localparam int DW     = SEL_W + ADDR_W + VAL_W;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mdata [N_MST];
`ifdef INTER_ARB_ROUND_ROBIN_EN
    int model_last = N_MST - 1;
`endif

    inter_arb_if #(.N_MST(N_MST), .N_SLV(N_SLV), .ADDR_W(ADDR_W), .VAL_W(VAL_W)) bus ();

    inter_arb #(.N_MST(N_MST), .N_SLV(N_SLV), .ADDR_W(ADDR_W), .VAL_W(VAL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Returns the master the arbitration rule serves next out of 'set'.
    function automatic int model_pick(input logic [N_MST-1:0] set);
        int m;
        m = -1;
`ifdef INTER_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N_MST; k++) begin
            int c;
            c = (model_last + k) % N_MST;
            if (m < 0 && ((set >> c) & N_MST'(1)) != 0) m = c;
        end
`else
        for (int c = N_MST - 1; c >= 0; c--) begin
            if (m < 0 && ((set >> c) & N_MST'(1)) != 0) m = c;
        end
`endif
        return m;
    endfunction

    // Queues the expected transfers for a burst of simultaneous requests.
    task automatic push_burst(input logic [N_MST-1:0] set);
        logic [N_MST-1:0] left;
        int m;
        left = set;
        while (left != 0) begin
            m = model_pick(left);
            left = left & ~(N_MST'(1) << m);
`ifdef INTER_ARB_ROUND_ROBIN_EN
            model_last = m;
`endif
            exp_q.push_back(mdata[m]);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
`ifdef INTER_ARB_ROUND_ROBIN_EN
        model_last = N_MST - 1;
`endif
    endtask

    function automatic logic [SEL_W-1:0] onehot_idx(input logic [N_SLV-1:0] v);
        onehot_idx = '0;
        for (int j = 0; j < N_SLV; j++) if (v[j]) onehot_idx = SEL_W'(j);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [N_MST-1:0] set);
        for (int i = 0; i < N_MST; i++) bus.data_in[i*DW +: DW] = mdata[i];
        bus.in_valid = set;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.in_valid = '0;
        step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_idle(input int budget, input bit rand_ready);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            if (rand_ready) bus.ready_slave = N_SLV'($urandom_range(0, (1 << N_SLV) - 1));
            step();
            if (exp_q.size() == 0 && bus.busy_master == '0 && bus.valid_slave == '0 &&
                bus.handshake_slave == '0) done = 1'b1;
        end
        bus.ready_slave = '1;
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL idle_timeout: %0d transfers outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic monitor();
        logic [N_SLV-1:0]  prev_valid;
        logic [ADDR_W-1:0] prev_addr;
        logic [VAL_W-1:0]  prev_val;
        logic              prev_hs;
        logic [DW-1:0]     act;
        logic [DW-1:0]     expv;
        prev_valid = '0;
        prev_addr  = '0;
        prev_val   = '0;
        prev_hs    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = '0;
                prev_hs    = 1'b0;
            end else begin
                n_cmp++;
                if ($countones(bus.valid_slave) > 1) begin
                    n_fail++;
                    $display("FAIL valid_onehot: got %b, required at most one bit", bus.valid_slave);
                end
                n_cmp++;
                if ($countones(bus.handshake_slave) > 1) begin
                    n_fail++;
                    $display("FAIL hs_onehot: got %b, required at most one bit", bus.handshake_slave);
                end
                n_cmp++;
                if (bus.valid_slave != '0 && bus.handshake_slave != '0) begin
                    n_fail++;
                    $display("FAIL valid_hs_overlap: valid %b hs %b, required not both", bus.valid_slave, bus.handshake_slave);
                end
                if (bus.valid_slave != '0 && bus.valid_slave == prev_valid) begin
                    n_cmp++;
                    if (bus.addr_out !== prev_addr || bus.value_out !== prev_val) begin
                        n_fail++;
                        $display("FAIL payload_stable: got %h/%h, required %h/%h", bus.addr_out, bus.value_out, prev_addr, prev_val);
                    end
                end
                if (bus.handshake_slave != '0) begin
                    n_cmp++;
                    if (prev_hs) begin
                        n_fail++;
                        $display("FAIL hs_pulse_width: handshake high two cycles, required one");
                    end
                    n_cmp++;
                    if (bus.handshake_slave !== prev_valid) begin
                        n_fail++;
                        $display("FAIL hs_slave: got %b, required %b", bus.handshake_slave, prev_valid);
                    end
                    act = {onehot_idx(prev_valid), prev_addr, prev_val};
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_transfer: got %h, required none", act);
                    end else begin
                        expv = exp_q.pop_front();
                        if (act !== expv) begin
                            n_fail++;
                            $display("FAIL transfer: got %h, required %h", act, expv);
                        end
                    end
                end
                prev_valid = bus.valid_slave;
                prev_addr  = bus.addr_out;
                prev_val   = bus.value_out;
                prev_hs    = |bus.handshake_slave;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid    = '0;
        bus.data_in     = '0;
        bus.ready_slave = '0;
        step();
        step();
        n_cmp++; if (bus.valid_slave !== '0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", bus.valid_slave); end
        n_cmp++; if (bus.handshake_slave !== '0) begin n_fail++; $display("FAIL reset_hs: got %b, required 0", bus.handshake_slave); end
        n_cmp++; if (bus.addr_out !== '0) begin n_fail++; $display("FAIL reset_addr: got %h, required 0", bus.addr_out); end
        n_cmp++; if (bus.value_out !== '0) begin n_fail++; $display("FAIL reset_value: got %h, required 0", bus.value_out); end
        n_cmp++; if (bus.busy_master !== '0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", bus.busy_master); end
        // IDLE is encoded as zero.
        n_cmp++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d, required 0", state_dbg); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        bus.ready_slave = '1;
        mdata[1] = 8'hAB;
        push_burst(4'b0010);
        drive_req(4'b0010);
        step();
        bus.in_valid = '0;
        n_cmp++; if (bus.busy_master !== 4'b0010) begin n_fail++; $display("FAIL single_busy: got %b, required 0010", bus.busy_master); end
        n_cmp++; if (bus.valid_slave !== 4'b0000) begin n_fail++; $display("FAIL single_early_valid: got %b, required 0000", bus.valid_slave); end
        step();
        n_cmp++; if (bus.valid_slave !== 4'b0100) begin n_fail++; $display("FAIL single_valid: got %b, required 0100", bus.valid_slave); end
        n_cmp++; if (bus.addr_out !== 3'd5) begin n_fail++; $display("FAIL single_addr: got %0d, required 5", bus.addr_out); end
        n_cmp++; if (bus.value_out !== 3'd3) begin n_fail++; $display("FAIL single_value: got %0d, required 3", bus.value_out); end
        step();
        n_cmp++; if (bus.handshake_slave !== 4'b0100) begin n_fail++; $display("FAIL single_hs: got %b, required 0100", bus.handshake_slave); end
        n_cmp++; if (bus.addr_out !== 3'd0 || bus.value_out !== 3'd0) begin n_fail++; $display("FAIL single_clear: got %h/%h, required 0/0", bus.addr_out, bus.value_out); end
        step();
        n_cmp++; if (bus.handshake_slave !== 4'b0000) begin n_fail++; $display("FAIL single_hs_end: got %b, required 0000", bus.handshake_slave); end
        wait_idle(20, 1'b0);
    endtask

    task automatic test_stall();
        int hs_cnt;
        bus.ready_slave = '0;
        mdata[0] = 8'h00;
        push_burst(4'b0001);
        drive_req(4'b0001);
        step();
        bus.in_valid = '0;
        step();
        n_cmp++; if (bus.valid_slave !== 4'b0001) begin n_fail++; $display("FAIL stall_valid_start: got %b, required 0001", bus.valid_slave); end
        for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++;
            if (bus.valid_slave !== 4'b0001 || bus.handshake_slave !== '0 || bus.addr_out !== '0 || bus.value_out !== '0) begin
                n_fail++;
                $display("FAIL stall_hold: valid %b hs %b payload %h/%h, required 0001 0000 0/0",
                         bus.valid_slave, bus.handshake_slave, bus.addr_out, bus.value_out);
            end
        end
        bus.ready_slave = 4'b0001;
        hs_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.handshake_slave != '0) hs_cnt++;
        end
        n_cmp++; if (hs_cnt != 1) begin n_fail++; $display("FAIL stall_hs_count: got %0d, required 1", hs_cnt); end
        wait_idle(20, 1'b0);
    endtask

    task automatic test_order();
        apply_reset();
        bus.ready_slave = '1;
        mdata[0] = 8'h11;
        mdata[2] = 8'h5A;
        mdata[3] = 8'hE7;
`ifdef INTER_ARB_ROUND_ROBIN_EN
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hE7);
        model_last = 3;
`else
        exp_q.push_back(8'hE7);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h11);
`endif
        drive_req(4'b1101);
        step();
        bus.in_valid = '0;
        wait_idle(40, 1'b0);
    endtask

    task automatic test_busy_ignore();
        bit seen;
        bus.ready_slave = '0;
        mdata[2] = 8'h4D;
        push_burst(4'b0100);
        drive_req(4'b0100);
        step();
        bus.in_valid = '0;
        n_cmp++; if (bus.busy_master[2] !== 1'b1) begin n_fail++; $display("FAIL ignore_busy: got %b, required 1", bus.busy_master[2]); end
        mdata[2] = 8'hF2;
        drive_req(4'b0100);
        step();
        bus.in_valid = '0;
        step();
        bus.ready_slave = '1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (bus.handshake_slave != '0) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL ignore_hs_timeout: got no handshake, required one"); end
        mdata[2] = 8'h9C;
        push_burst(4'b0100);
        drive_req(4'b0100);
        step();
        bus.in_valid = '0;
        n_cmp++; if (bus.busy_master[2] !== 1'b1) begin n_fail++; $display("FAIL hs_cycle_capture: got %b, required 1", bus.busy_master[2]); end
        wait_idle(40, 1'b0);
    endtask

    task automatic test_back_to_back();
        bus.ready_slave = '1;
        mdata[1] = 8'h37;
        push_burst(4'b0010);
        drive_req(4'b0010);
        step();
        bus.in_valid = '0;
        step();
        n_cmp++; if (bus.valid_slave !== 4'b0001) begin n_fail++; $display("FAIL b2b_valid1: got %b, required 0001", bus.valid_slave); end
        mdata[1] = 8'hC8;
        push_burst(4'b0010);
        drive_req(4'b0010);
        step();
        bus.in_valid = '0;
        n_cmp++; if (bus.handshake_slave !== 4'b0001) begin n_fail++; $display("FAIL b2b_hs1: got %b, required 0001", bus.handshake_slave); end
        n_cmp++; if (bus.busy_master[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_set_wins: got %b, required 1", bus.busy_master[1]); end
        step();
        n_cmp++; if (bus.valid_slave !== 4'b1000 || bus.addr_out !== 3'd1 || bus.value_out !== 3'd0) begin
            n_fail++;
            $display("FAIL b2b_valid2: got %b %0d/%0d, required 1000 1/0", bus.valid_slave, bus.addr_out, bus.value_out);
        end
        wait_idle(40, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit seen;
        bus.ready_slave = '0;
        mdata[1] = DW'($urandom);
        mdata[3] = DW'($urandom);
        drive_req(4'b1010);
        step();
        bus.in_valid = '0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step();
            if (bus.valid_slave != '0) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL rstmid_send: got no valid, required one"); end
        rst = 1'b1;
        step();
        n_cmp++; if (bus.valid_slave !== '0) begin n_fail++; $display("FAIL rstmid_valid: got %b, required 0", bus.valid_slave); end
        n_cmp++; if (bus.handshake_slave !== '0) begin n_fail++; $display("FAIL rstmid_hs: got %b, required 0", bus.handshake_slave); end
        n_cmp++; if (bus.addr_out !== '0 || bus.value_out !== '0) begin n_fail++; $display("FAIL rstmid_payload: got %h/%h, required 0/0", bus.addr_out, bus.value_out); end
        n_cmp++; if (bus.busy_master !== '0) begin n_fail++; $display("FAIL rstmid_busy: got %b, required 0", bus.busy_master); end
        rst = 1'b0;
        model_reset();
        bus.ready_slave = '1;
        for (int c = 0; c < 8; c++) begin
            step();
            n_cmp++;
            if (bus.handshake_slave !== '0 || bus.valid_slave !== '0 || bus.busy_master !== '0) begin
                n_fail++;
                $display("FAIL rstmid_quiet: hs %b valid %b busy %b, required all 0",
                         bus.handshake_slave, bus.valid_slave, bus.busy_master);
            end
        end
    endtask

    task automatic test_random();
        logic [N_MST-1:0] set;
        for (int it = 0; it < 30; it++) begin
            set = N_MST'($urandom_range(1, (1 << N_MST) - 1));
            for (int i = 0; i < N_MST; i++) mdata[i] = DW'($urandom);
            push_burst(set);
            drive_req(set);
            step();
            bus.in_valid = '0;
            wait_idle(400, 1'b1);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.in_valid    = '0;
        bus.data_in     = '0;
        bus.ready_slave = '0;
        for (int i = 0; i < N_MST; i++) mdata[i] = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_stall();
        test_order();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
